accum_seq: RTL and testbench
============================

ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 Parameter bit_width, default 16, is the operand/result width.
REQ-002 Parameter cnt_width, default 8, is the operand-count width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a new accumulation job; sampled only in IDLE.
REQ-006 len  input  cnt_width  number of operands in the job; latched when start is accepted.
REQ-007 in_valid  input  1  operand present on in_data/in_sub.
REQ-008 in_data  input  bit_width  operand value.
REQ-009 in_sub  input  1  1 = subtract operand, 0 = add operand.
REQ-010 in_ready  output  1  block accepts an operand this cycle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 out_valid  output  1  result available on out_data.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_data  output  bit_width  accumulated result.

Function
REQ-015 The block SHALL contain the accumulator datapath: register acc, loaded with the operand on the first transfer of a job (init), else acc + operand + sign.
REQ-016 Add: operand = in_data, sign = 0; subtract: operand = ~in_data, sign = 1, giving acc - in_data.
REQ-017 First operand with in_sub=1 SHALL load acc = 0 - in_data (two's complement).
REQ-018 Arithmetic SHALL be modulo 2^bit_width; carry-out discarded, no saturation.
REQ-019 States: IDLE, FIRST, ACC, DONE.
REQ-020 IDLE: in_ready=0, out_valid=0; start=1 latches len into remaining counter; len!=0 -> FIRST, len=0 -> DONE with acc cleared to 0.
REQ-021 FIRST: in_ready=1; on in_valid&in_ready acc loads per REQ-015/017, remaining decrements; remaining was 1 -> DONE, else -> ACC.
REQ-022 ACC: in_ready=1; each transfer updates acc and decrements remaining; last transfer -> DONE.
REQ-023 in_valid=0 in FIRST/ACC SHALL hold state, acc, remaining (bubbles allowed, no timeout).
REQ-024 Latency: result visible (out_valid=1, out_data=acc) the cycle after the last operand transfer.
REQ-025 DONE: out_valid=1, out_data stable until out_valid&out_ready; then -> IDLE next cycle.
REQ-026 start SHALL be ignored outside IDLE, including DONE with out_ready=1 same cycle; a new job needs start in IDLE.
REQ-027 len and in_sub changes during a job SHALL not affect the latched count.
REQ-028 out_data SHALL equal acc in all states; only qualified by out_valid.

Reset
REQ-029 rst=1 SHALL force IDLE, acc=0, remaining=0, in_ready=0, busy=0, out_valid=0, out_data=0 immediately, regardless of clk.
REQ-030 Reset mid-job SHALL abandon the job; no result emitted; first start after reset release begins a fresh job.

Verification
REQ-031 Reset then start, len=3, operands +5,+7,+10 back-to-back -> out_valid one cycle after third transfer, out_data=22.
REQ-032 len=2, operands sub 3 then add 1 -> out_data=0xFFFE (-2).
REQ-033 len=2, operands 0xFFFF, 0x0002 -> out_data=0x0001 (wrap, no flag).
REQ-034 len=0 start -> DONE next cycle, out_data=0, in_ready never asserted; out_ready held low 5 cycles -> out_valid and data held; start pulses during DONE ignored.
REQ-035 len=4 with in_valid gaps of 2 cycles between operands 1,2,3,4 -> out_data=10, busy high throughout.
REQ-036 rst asserted asynchronously after second operand of len=4 job -> all outputs 0 before next clk edge; subsequent len=1, operand 9 job -> out_data=9.

Source files
------------

// File: rtl/accum_seq.sv
// Sequenced accumulator that sums or subtracts a counted burst of operands.
// Each result is held on a ready/valid output until the consumer takes it.
//   state | meaning
//   IDLE  | waiting for start; result of the previous job still on out_data
//   FIRST | waiting for the first operand, which loads acc
//   ACC   | accumulating the remaining operands
//   DONE  | result valid, waiting for out_ready
module accum_seq #(
  parameter int bit_width = 16,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cnt_width-1:0] len,
  input  logic                 in_valid,
  input  logic [bit_width-1:0] in_data,
  input  logic                 in_sub,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_width-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, FIRST, ACC, DONE} state_t;

  state_t               state_q;
  logic [bit_width-1:0] acc_q, acc_d, operand;
  logic [cnt_width-1:0] rem_q;
  logic                 in_ready_q, busy_q, out_valid_q;

  // Subtraction is ~x + 1; in FIRST the base is zero, so a subtracted first operand gives 0 - x.
  always_comb begin
    operand = in_sub ? ~in_data : in_data;
    acc_d   = ((state_q == FIRST) ? '0 : acc_q) + operand
              + {{(bit_width-1){1'b0}}, in_sub};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q  <= len;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= FIRST;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              acc_q       <= '0;
              out_valid_q <= 1'b1;
            end
          end
        end
        FIRST, ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == {{(cnt_width-1){1'b0}}, 1'b1}) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq: hand-computed results for add/sub, wrap,
// zero-length jobs, bubbles, output backpressure and asynchronous reset.
module tb_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_sub;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;

  accum_seq #(.bit_width(16), .cnt_width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [15:0] d, input logic sub);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    step();
    in_valid = 1'b0;
  endtask

  task automatic begin_job(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_sub = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    step();
    rst = 1'b0;
    step();

    // 5 + 7 + 10 back to back
    begin_job(8'd3);
    check("j1_in_ready", in_ready, 1);
    check("j1_busy", busy, 1);
    xfer(16'd5, 1'b0);
    in_valid = 1'b1; in_data = 16'd7; step();
    in_data = 16'd10; step();
    in_valid = 1'b0;
    check("j1_out_valid", out_valid, 1);
    check("j1_out_data", out_data, 22);
    check("j1_in_ready_done", in_ready, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("j1_idle_valid", out_valid, 0);
    check("j1_idle_busy", busy, 0);

    // -3 + 1
    begin_job(8'd2);
    xfer(16'd3, 1'b1);
    check("j2_partial", out_data, 16'hFFFD);
    check("j2_not_done", out_valid, 0);
    xfer(16'd1, 1'b0);
    check("j2_out_valid", out_valid, 1);
    check("j2_out_data", out_data, 16'hFFFE);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // modulo wrap
    begin_job(8'd2);
    xfer(16'hFFFF, 1'b0);
    xfer(16'h0002, 1'b0);
    check("j3_out_data", out_data, 16'h0001);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // zero-length job, held result, start ignored in DONE
    begin_job(8'd0);
    check("j4_out_valid", out_valid, 1);
    check("j4_out_data", out_data, 0);
    check("j4_in_ready", in_ready, 0);
    start = 1'b1; len = 8'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("j4_hold_valid", out_valid, 1);
      check("j4_hold_data", out_data, 0);
      check("j4_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0; start = 1'b0;
    check("j4_release_valid", out_valid, 0);
    check("j4_release_busy", busy, 0);
    step();
    check("j4_no_restart_busy", busy, 0);
    check("j4_no_restart_ready", in_ready, 0);

    // bubbles of two cycles between operands
    begin_job(8'd4);
    for (int k = 1; k <= 4; k++) begin
      xfer(k[15:0], 1'b0);
      if (k < 4) begin
        step(); step();
        check("j5_bubble_busy", busy, 1);
        check("j5_bubble_valid", out_valid, 0);
      end
    end
    check("j5_out_valid", out_valid, 1);
    check("j5_out_data", out_data, 10);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // async reset mid-job
    begin_job(8'd4);
    xfer(16'd100, 1'b0);
    xfer(16'd200, 1'b0);
    check("j6_mid_data", out_data, 300);
    #2 rst = 1'b1;
    #1;
    check("j6_rst_data", out_data, 0);
    check("j6_rst_busy", busy, 0);
    check("j6_rst_in_ready", in_ready, 0);
    check("j6_rst_valid", out_valid, 0);
    step();
    rst = 1'b0;
    step();
    check("j6_after_idle", busy, 0);
    begin_job(8'd1);
    xfer(16'd9, 1'b0);
    check("j7_out_valid", out_valid, 1);
    check("j7_out_data", out_data, 9);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("j7_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
